// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: load-use bubbles, branch squash, memory-wait freeze.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall/flush/memwait cycle counters.
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  IF_ID_Rs1,
  input  logic [4:0]  IF_ID_Rs2,
  input  logic [4:0]  ID_EX_Rd,
  input  logic        ID_EX_MemRead,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        ID_EX_Write,
  output logic        EX_MEM_Write,
  output logic        ID_EX_Bubble,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush,
  output logic        MEM_WB_Bubble,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] stall_count,
  output logic [31:0] flush_count,
  output logic [31:0] memwait_count,
`endif
  output logic        mem_timeout
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

  localparam logic [2:0]  FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_VAL  = 16'(TIMEOUT);

  state_t      state, state_next;
  logic [2:0]  flush_cnt, flush_cnt_next;
  logic [15:0] wait_cnt, wait_cnt_next;
  logic        pend_flush, pend_flush_next;
  logic        timeout_next;
  logic        load_use, branch, wait_start, freeze, flush, stall;

  assign load_use   = ID_EX_MemRead && (ID_EX_Rd != 5'd0) &&
                      ((ID_EX_Rd == IF_ID_Rs1) || (ID_EX_Rd == IF_ID_Rs2));
  assign branch     = branch_taken || pend_flush;
  assign wait_start = mem_req && !mem_ready;

  always_comb begin
    state_next      = state;
    flush_cnt_next  = flush_cnt;
    wait_cnt_next   = wait_cnt;
    pend_flush_next = pend_flush;
    timeout_next    = mem_timeout;
    freeze          = 1'b0;
    flush           = 1'b0;
    stall           = 1'b0;

    case (state)
      RUN, FLUSH: begin
        if (wait_start) begin
          // A branch seen on the freeze-entry cycle is deferred, not dropped
          freeze          = 1'b1;
          state_next      = MEM_WAIT;
          wait_cnt_next   = 16'd1;
          pend_flush_next = pend_flush || branch_taken;
        end else if (branch) begin
          flush           = 1'b1;
          pend_flush_next = 1'b0;
          if (FLUSH_CYCLES > 1) begin
            state_next     = FLUSH;
            flush_cnt_next = FLUSH_RELOAD;
          end else begin
            state_next     = RUN;
            flush_cnt_next = 3'd0;
          end
        end else if (state == FLUSH) begin
          flush = 1'b1;
          if (flush_cnt <= 3'd1) begin
            state_next     = RUN;
            flush_cnt_next = 3'd0;
          end else begin
            flush_cnt_next = flush_cnt - 3'd1;
          end
        end else begin
          stall = load_use;
        end
      end
      MEM_WAIT: begin
        pend_flush_next = pend_flush || branch_taken;
        if (mem_ready) begin
          // The held load may still need its bubble once the pipe moves again
          state_next    = (flush_cnt != 3'd0) ? FLUSH : RUN;
          wait_cnt_next = 16'd0;
          stall         = load_use;
        end else begin
          freeze        = 1'b1;
          wait_cnt_next = wait_cnt + 16'd1;
        end
      end
      default: state_next = RUN;
    endcase

    // Abort a wait that has used up its cycle budget; an interrupted flush resumes
    if (state_next == MEM_WAIT && wait_cnt_next >= TIMEOUT_VAL) begin
      timeout_next  = 1'b1;
      state_next    = (flush_cnt_next != 3'd0) ? FLUSH : RUN;
      wait_cnt_next = 16'd0;
    end
  end

  always_comb begin
    PCWrite       = !freeze && !stall;
    IF_ID_Write   = !freeze && !stall;
    ID_EX_Write   = !freeze;
    EX_MEM_Write  = !freeze;
    ID_EX_Bubble  = stall;
    IF_ID_Flush   = flush;
    ID_EX_Flush   = flush;
    MEM_WB_Bubble = freeze;
    if (rst) begin
      PCWrite       = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Write   = 1'b0;
      EX_MEM_Write  = 1'b0;
      ID_EX_Bubble  = 1'b1;
      IF_ID_Flush   = 1'b0;
      ID_EX_Flush   = 1'b0;
      MEM_WB_Bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      flush_cnt   <= 3'd0;
      wait_cnt    <= 16'd0;
      pend_flush  <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_next;
      flush_cnt   <= flush_cnt_next;
      wait_cnt    <= wait_cnt_next;
      pend_flush  <= pend_flush_next;
      mem_timeout <= timeout_next;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count   <= 32'd0;
      flush_count   <= 32'd0;
      memwait_count <= 32'd0;
    end else begin
      if (stall && stall_count != 32'hFFFF_FFFF)
        stall_count <= stall_count + 32'd1;
      if (flush && flush_count != 32'hFFFF_FFFF)
        flush_count <= flush_count + 32'd1;
      if (state == MEM_WAIT && memwait_count != 32'hFFFF_FFFF)
        memwait_count <= memwait_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl with FLUSH_CYCLES=3, TIMEOUT=8.
module tb_pipeline_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] IF_ID_Rs1, IF_ID_Rs2, ID_EX_Rd;
  logic       ID_EX_MemRead, branch_taken, mem_req, mem_ready;
  logic       PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write;
  logic       ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_count, flush_count, memwait_count;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  // {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble}
  logic [7:0] outs;
  assign outs = {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
                 ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble};

  localparam logic [7:0] RUN_O  = 8'b1111_0000;
  localparam logic [7:0] RST_O  = 8'b0000_1001;
  localparam logic [7:0] LU_O   = 8'b0011_1000;
  localparam logic [7:0] FL_O   = 8'b1111_0110;
  localparam logic [7:0] WAIT_O = 8'b0000_0001;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_Rs1(IF_ID_Rs1), .IF_ID_Rs2(IF_ID_Rs2), .ID_EX_Rd(ID_EX_Rd),
    .ID_EX_MemRead(ID_EX_MemRead), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Write(ID_EX_Write),
    .EX_MEM_Write(EX_MEM_Write), .ID_EX_Bubble(ID_EX_Bubble),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
    .MEM_WB_Bubble(MEM_WB_Bubble),
`ifdef HAZARD_PERF_CNT_EN
    .stall_count(stall_count), .flush_count(flush_count), .memwait_count(memwait_count),
`endif
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  // Advance one cycle; new inputs are driven 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic br, input logic mq, input logic rdy);
    ID_EX_MemRead = mr; ID_EX_Rd = rd; IF_ID_Rs1 = rs1; IF_ID_Rs2 = rs2;
    branch_taken = br; mem_req = mq; mem_ready = rdy;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    total_cnt++;
    if (outs !== RST_O || mem_timeout !== 1'b0)
      $display("FAIL reset: outs=%b timeout=%b expected %b/0", outs, mem_timeout, RST_O);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    total_cnt++;
    if (outs !== RUN_O) $display("FAIL run_default: outs=%b expected %b", outs, RUN_O);
    else pass_cnt++;
  endtask

  task automatic test_load_use();
    drive(1, 5, 0, 5, 0, 0, 0);
    total_cnt++;
    if (outs !== LU_O) $display("FAIL load_use_rs2: outs=%b expected %b", outs, LU_O);
    else pass_cnt++;
    tick();
    drive(0, 0, 0, 5, 0, 0, 0);
    total_cnt++;
    if (outs !== RUN_O) $display("FAIL load_use_clear: outs=%b expected %b", outs, RUN_O);
    else pass_cnt++;
    tick();
    drive(1, 7, 7, 3, 0, 0, 0);
    total_cnt++;
    if (outs !== LU_O) $display("FAIL load_use_rs1: outs=%b expected %b", outs, LU_O);
    else pass_cnt++;
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    total_cnt++;
    if (outs !== RUN_O) $display("FAIL load_use_x0: outs=%b expected %b", outs, RUN_O);
    else pass_cnt++;
    tick();
    drive(0, 6, 6, 6, 0, 0, 0);
    total_cnt++;
    if (outs !== RUN_O) $display("FAIL no_load_match: outs=%b expected %b", outs, RUN_O);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_branch();
    drive(0, 0, 0, 0, 1, 0, 0);
    for (int c = 0; c < 4; c++) begin
      total_cnt++;
      if (outs !== ((c < 3) ? FL_O : RUN_O))
        $display("FAIL branch_c%0d: outs=%b expected %b", c, outs, (c < 3) ? FL_O : RUN_O);
      else pass_cnt++;
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
    end
    // Load-use coinciding with a branch: the dependent instruction is squashed instead
    drive(1, 5, 5, 0, 1, 0, 0);
    total_cnt++;
    if (outs !== FL_O) $display("FAIL branch_load_use: outs=%b expected %b", outs, FL_O);
    else pass_cnt++;
    tick(); drive(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    total_cnt++;
    if (outs !== RUN_O) $display("FAIL branch_lu_drain: outs=%b expected %b", outs, RUN_O);
    else pass_cnt++;
  endtask

  task automatic test_mem_wait();
    drive(0, 0, 0, 0, 0, 1, 0);
    for (int c = 0; c < 4; c++) begin
      total_cnt++;
      if (outs !== WAIT_O) $display("FAIL mem_wait_c%0d: outs=%b expected %b", c, outs, WAIT_O);
      else pass_cnt++;
      tick();
      drive(0, 0, 0, 0, 0, 1, 0);
    end
    drive(0, 0, 0, 0, 0, 1, 1);
    total_cnt++;
    if (outs !== RUN_O) $display("FAIL mem_ready: outs=%b expected %b", outs, RUN_O);
    else pass_cnt++;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_wait_pending_branch();
    logic [7:0] exp [0:7];
    exp = '{WAIT_O, WAIT_O, WAIT_O, RUN_O, FL_O, FL_O, FL_O, RUN_O};
    for (int c = 0; c < 8; c++) begin
      drive(0, 0, 0, 0, c == 1, c < 4, c == 3);
      total_cnt++;
      if (outs !== exp[c])
        $display("FAIL wait_branch_c%0d: outs=%b expected %b", c, outs, exp[c]);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_flush_interrupted();
    logic [7:0] exp [0:5];
    exp = '{FL_O, WAIT_O, RUN_O, FL_O, FL_O, RUN_O};
    for (int c = 0; c < 6; c++) begin
      drive(0, 0, 0, 0, c == 0, c == 1 || c == 2, c == 2);
      total_cnt++;
      if (outs !== exp[c])
        $display("FAIL flush_interrupt_c%0d: outs=%b expected %b", c, outs, exp[c]);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_timeout();
    for (int c = 0; c < 8; c++) begin
      drive(0, 0, 0, 0, 0, 1, 0);
      total_cnt++;
      if (outs !== WAIT_O || mem_timeout !== 1'b0)
        $display("FAIL timeout_wait_c%0d: outs=%b timeout=%b expected %b/0", c, outs, mem_timeout, WAIT_O);
      else pass_cnt++;
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    total_cnt++;
    if (outs !== RUN_O || mem_timeout !== 1'b1)
      $display("FAIL timeout_set: outs=%b timeout=%b expected %b/1", outs, mem_timeout, RUN_O);
    else pass_cnt++;
    tick(); tick();
    total_cnt++;
    if (mem_timeout !== 1'b1) $display("FAIL timeout_sticky: timeout=%b expected 1", mem_timeout);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    drive(0, 0, 0, 0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    total_cnt++;
    if (outs !== FL_O) $display("FAIL pre_reset_flush: outs=%b expected %b", outs, FL_O);
    else pass_cnt++;
    #1 rst = 1'b1;
    #1;
    total_cnt++;
    if (outs !== RST_O || mem_timeout !== 1'b0)
      $display("FAIL async_reset: outs=%b timeout=%b expected %b/0", outs, mem_timeout, RST_O);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    tick();
    total_cnt++;
    if (outs !== RUN_O) $display("FAIL post_reset: outs=%b expected %b", outs, RUN_O);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (outs !== RUN_O) $display("FAIL post_reset_2: outs=%b expected %b", outs, RUN_O);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_wait_pending_branch();
    test_flush_interrupted();
    test_timeout();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Sits beside the forwarding logic and resolves the hazards forwarding cannot cover:
  - load-use data hazards (one-cycle bubble)
  - taken branches/jumps resolved in EX/MEM (squash younger stages)
  - multi-cycle data-memory waits (freeze the whole pipeline)
- Drives the write-enable/flush controls of the PC and all pipeline registers.

Parameters:
- FLUSH_CYCLES, 1, cycles IF/ID and ID/EX flush stays asserted per taken branch (1..7).
- TIMEOUT, 255, max consecutive memory-wait cycles before abort (1..65535).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- IF_ID_Rs1  in  5  source reg 1 of instruction in ID
- IF_ID_Rs2  in  5  source reg 2 of instruction in ID
- ID_EX_Rd  in  5  destination of instruction in EX
- ID_EX_MemRead  in  1  instruction in EX is a load
- branch_taken  in  1  taken branch/jump resolved this cycle
- mem_req  in  1  data-memory access active in MEM
- mem_ready  in  1  data memory completes access this cycle
- PCWrite  out  1  PC update enable
- IF_ID_Write  out  1  IF/ID register enable
- ID_EX_Write  out  1  ID/EX register enable
- EX_MEM_Write  out  1  EX/MEM register enable
- ID_EX_Bubble  out  1  insert NOP into ID/EX (zero control bits)
- IF_ID_Flush  out  1  clear IF/ID to NOP
- ID_EX_Flush  out  1  clear ID/EX to NOP
- MEM_WB_Bubble  out  1  insert NOP into MEM/WB
- mem_timeout  out  1  sticky: memory wait exceeded TIMEOUT

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. State, counters and mem_timeout are registered. All enable/flush outputs are combinational from state + inputs.
- Reset outputs while rst=1:
  - all *_Write = 0
  - ID_EX_Bubble = 1, MEM_WB_Bubble = 1
  - both flushes = 0
  - mem_timeout = 0
  - state = RUN
- States: RUN, MEM_WAIT, FLUSH.
- Default outputs in RUN with no hazard: all *_Write = 1, all bubble/flush = 0.
- Load-use (RUN only): ID_EX_MemRead && ID_EX_Rd != 0 && (ID_EX_Rd == IF_ID_Rs1 || ID_EX_Rd == IF_ID_Rs2) causes, in the same cycle:
  - PCWrite = 0, IF_ID_Write = 0, ID_EX_Bubble = 1
  - no state change; the condition self-clears next cycle because the bubble has no MemRead
  - zero latency; exactly one bubble per load-use pair
- Taken branch (RUN, no memory wait):
  - branch_taken = 1 asserts IF_ID_Flush = 1 and ID_EX_Flush = 1 that cycle
  - if FLUSH_CYCLES > 1, go to FLUSH and keep both flushes asserted for FLUSH_CYCLES-1 further cycles (down-counter), then return to RUN
  - PCWrite stays 1 so the branch target loads
- Memory wait:
  - mem_req && !mem_ready in RUN or FLUSH: go to MEM_WAIT
  - in MEM_WAIT: PCWrite = IF_ID_Write = ID_EX_Write = EX_MEM_Write = 0, MEM_WB_Bubble = 1, flushes = 0
  - the same-cycle freeze is also applied combinationally on the entry cycle
  - mem_ready = 1: MEM_WAIT → RUN, outputs return to RUN values that cycle
  - a 16-bit wait counter increments each MEM_WAIT cycle; reaching TIMEOUT sets mem_timeout (sticky until rst) and forces → RUN
- Priority (simultaneous events): memory wait > branch flush > load-use.
  - branch_taken during a memory wait is latched in pend_flush and applied on the first RUN cycle after the wait
  - load-use in the same cycle as branch_taken: flush only, no bubble, PCWrite = 1 (the dependent instruction is squashed)
- FLUSH interrupted by a memory wait: the flush counter is frozen and resumes after the wait.
- Reset mid-operation: immediate return to the reset outputs, pending flush and counters cleared.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds 32-bit outputs stall_count, flush_count, memwait_count.
  - each counts cycles with load-use bubble, flush asserted, and MEM_WAIT respectively
  - cleared by rst; saturate at 0xFFFFFFFF
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Load-use: ID_EX_MemRead=1, ID_EX_Rd=5, IF_ID_Rs2=5 for one cycle → PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1 that cycle only. Repeat with ID_EX_Rd=0 → no stall.
- Branch, FLUSH_CYCLES=3: branch_taken pulse → IF_ID_Flush=ID_EX_Flush=1 for exactly 3 cycles, PCWrite=1 throughout.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles, then mem_ready=1 → all *_Write=0 and MEM_WB_Bubble=1 for 4 cycles; normal outputs on the ready cycle.
- Wait during pending branch: branch_taken in the 2nd wait cycle → no flush during the wait; flush for FLUSH_CYCLES starting the cycle after mem_ready.
- Timeout, TIMEOUT=8: mem_ready held 0 → mem_timeout=1 after 8 wait cycles, state RUN, flag stays 1 until rst.
- Async reset asserted mid-FLUSH, between clock edges → outputs take reset values immediately; after release, no residual flush.
